// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative MULTU/DIVU unit.
// Optional build macro: MULDIV_ZERO_SKIP_EN (zero-operand short-circuit).
package muldiv_pkg;

  // Default operand width; HI and LO are each this wide.
  localparam int unsigned MULDIV_WIDTH = 32;

  // Iteration counter width, ceil(log2(WIDTH+1)).
  localparam int unsigned MULDIV_CNT_W = $clog2(MULDIV_WIDTH + 1);

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } muldiv_state_e;

  // Counter width for a non-default operand width.
  function automatic int unsigned muldiv_cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide (combinational).
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MULDIV_WIDTH
) (
  input  logic             mode_div,   // 0: multiply step, 1: divide step
  input  logic [WIDTH-1:0] acc_in,     // acc_hi (multiply) or remainder (divide)
  input  logic [WIDTH-1:0] q_in,       // acc_lo (multiply) or quotient (divide)
  input  logic [WIDTH-1:0] operand,    // multiplier or divisor
  output logic [WIDTH-1:0] acc_nxt_c,
  output logic [WIDTH-1:0] q_nxt_c
);

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_acc;
  logic [WIDTH-1:0] mul_q;
  logic [WIDTH:0]   div_rem_sh;
  logic             div_fits;
  logic [WIDTH-1:0] div_acc;
  logic [WIDTH-1:0] div_q;

  // Multiply: conditional add into a carry-extended sum, then shift {carry,hi,lo} right.
  always_comb begin
    mul_sum = {1'b0, acc_in} + (q_in[0] ? {1'b0, operand} : '0);
    mul_acc = mul_sum[WIDTH:1];
    mul_q   = {mul_sum[0], q_in[WIDTH-1:1]};
  end

  // Divide: shift {r,q} left, keep the trial difference when it does not borrow.
  // The stored remainder is always below the divisor, so WIDTH bits hold it.
  always_comb begin
    div_rem_sh = {acc_in, q_in[WIDTH-1]};
    div_fits   = (div_rem_sh >= {1'b0, operand});
    div_acc    = div_fits ? WIDTH'(div_rem_sh - {1'b0, operand})
                          : div_rem_sh[WIDTH-1:0];
    div_q      = {q_in[WIDTH-2:0], div_fits};
  end

  // Select the datapath for the active mode.
  always_comb begin
    acc_nxt_c = mode_div ? div_acc : mul_acc;
    q_nxt_c   = mode_div ? div_q   : mul_q;
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative unsigned MULTU/DIVU unit owning the architectural HI/LO registers.
// Optional build macro: MULDIV_ZERO_SKIP_EN completes zero-operand cases at launch.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MULDIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_div,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = muldiv_cnt_width(WIDTH);

  muldiv_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] acc_q,   acc_d;
  logic [WIDTH-1:0] qr_q,    qr_d;
  logic [WIDTH-1:0] opb_q,   opb_d;
  logic [WIDTH-1:0] hi_q,    hi_d;
  logic [WIDTH-1:0] lo_q,    lo_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;

  logic             zero_skip_c;
  logic [WIDTH-1:0] step_acc_c;
  logic [WIDTH-1:0] step_q_c;
  logic             last_iter_c;

  // Single-iteration datapath shared by both operations.
  muldiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .mode_div  (state_q == DIV),
    .acc_in    (acc_q),
    .q_in      (qr_q),
    .operand   (opb_q),
    .acc_nxt_c (step_acc_c),
    .q_nxt_c   (step_q_c)
  );

  // Detect operations whose result is known without iterating.
  always_comb begin
    zero_skip_c = 1'b0;
`ifdef MULDIV_ZERO_SKIP_EN
    if (op_div) begin
      zero_skip_c = (src_b == '0);
    end else begin
      zero_skip_c = (src_a == '0) || (src_b == '0);
    end
`endif
  end

  assign last_iter_c = (cnt_q == CNT_W'(WIDTH - 1));

  // Next-state, datapath and HI/LO update logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    qr_d    = qr_q;
    opb_d   = opb_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && zero_skip_c) begin
          hi_d   = op_div ? src_a : '0;
          lo_d   = op_div ? '1    : '0;
          done_d = 1'b1;
        end else if (start) begin
          acc_d   = '0;
          qr_d    = src_a;
          opb_d   = src_b;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = op_div ? DIV : MUL;
        end
      end

      MUL, DIV: begin
        acc_d  = step_acc_c;
        qr_d   = step_q_c;
        cnt_d  = cnt_q + CNT_W'(1);
        busy_d = 1'b1;
        if (last_iter_c) begin
          hi_d    = step_acc_c;
          lo_d    = step_q_c;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      qr_q    <= '0;
      opb_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      qr_q    <= qr_d;
      opb_q   <= opb_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
